ldpc_ext_sub: RTL and testbench



---
 rtl/ldpc_pkg.sv | 30 +++
 rtl/ldpc_msg_buf.sv | 27 ++
 rtl/ldpc_ext_sub.sv | 100 ++++++++++
 tb/tb_ldpc_ext_sub.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/ldpc_pkg.sv
// Shared types and helpers for the LDPC node datapath.
// LDPC_EXT_SAT_EN selects saturating (defined) or wrapping (undefined) message fitting.
package ldpc_pkg;

    localparam int MSG_W = 8;

    typedef logic signed [MSG_W-1:0] msg_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        EMIT = 2'd2
    } state_t;

    // Fits a wide signed value into a w-bit signed message; the caller keeps the low w bits.
    function automatic int sat_fit(input int v, input int w);
`ifdef LDPC_EXT_SAT_EN
        int hi;
        int lo;
        hi = (1 <<< (w - 1)) - 1;
        lo = -(1 <<< (w - 1));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
`else
        return (v <<< (32 - w)) >>> (32 - w);
`endif
    endfunction

endpackage

// File: rtl/ldpc_msg_buf.sv
// Message buffer for one node group: DEPTH x WIDTH register file,
// one synchronous write port and one combinational read port.
module ldpc_msg_buf
    import ldpc_pkg::*;
#(
    parameter int WIDTH = MSG_W,
    parameter int DEPTH = 8,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    we,
    input  logic [PTR_W-1:0]        waddr,
    input  logic signed [WIDTH-1:0] wdata,
    input  logic [PTR_W-1:0]        raddr,
    output logic signed [WIDTH-1:0] rdata
);

    logic signed [WIDTH-1:0] mem [DEPTH];

    // Storage only; contents are meaningless until written in the current group.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/ldpc_ext_sub.sv
// Extrinsic-message distributor: buffers a node's message group, then emits sum minus own
// message per edge in arrival order. LDPC_EXT_SAT_EN enables output saturation.
module ldpc_ext_sub
    import ldpc_pkg::*;
#(
    parameter int WIDTH = MSG_W,
    parameter int DEPTH = 8,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    xrst,
    input  logic signed [WIDTH-1:0] i_data,
    input  logic                    i_val,
    input  logic                    i_last,
    output logic                    i_ready,
    output logic signed [WIDTH-1:0] o_data,
    output logic                    o_val,
    output logic                    o_last
);

    localparam int SUM_W = WIDTH + PTR_W + 1;
    localparam int CNT_W = PTR_W + 1;

    state_t                  state, state_nx;
    logic [CNT_W-1:0]        count;
    logic [PTR_W-1:0]        idx;
    logic signed [SUM_W-1:0] sum;
    logic signed [WIDTH-1:0] rd_data;
    logic                    accept;
    logic                    full;
    logic                    emit_last;

    function automatic logic signed [WIDTH-1:0] fit(input logic signed [SUM_W-1:0] v);
        return WIDTH'(sat_fit(32'(v), WIDTH));
    endfunction

    assign i_ready   = (state != EMIT);
    assign accept    = i_val && i_ready;
    assign full      = (count == CNT_W'(DEPTH - 1));
    assign emit_last = ({1'b0, idx} == count - CNT_W'(1));

    ldpc_msg_buf #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_buf (
        .clk   (clk),
        .we    (accept),
        .waddr (count[PTR_W-1:0]),
        .wdata (i_data),
        .raddr (idx),
        .rdata (rd_data)
    );

    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) state <= IDLE;
        else       state <= state_nx;
    end

    // The DEPTH-th message closes the group even without i_last.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = i_last ? EMIT : ACC;
            ACC:     if (accept && (i_last || full)) state_nx = EMIT;
            EMIT:    if (emit_last) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            count  <= '0;
            idx    <= '0;
            sum    <= '0;
            o_data <= '0;
            o_val  <= 1'b0;
            o_last <= 1'b0;
        end else if (state == EMIT) begin
            o_data <= fit(sum - SUM_W'(rd_data));
            o_val  <= 1'b1;
            o_last <= emit_last;
            if (emit_last) begin
                count <= '0;
                idx   <= '0;
                sum   <= '0;
            end else begin
                idx <= idx + PTR_W'(1);
            end
        end else begin
            o_val  <= 1'b0;
            o_last <= 1'b0;
            if (accept) begin
                count <= count + CNT_W'(1);
                sum   <= sum + SUM_W'(i_data);
            end
        end
    end

endmodule

// File: tb/tb_ldpc_ext_sub.sv
// Bench for ldpc_ext_sub: directed vector table, hand-written corner sequences,
// and random groups checked against an arithmetic reference model.
module tb_ldpc_ext_sub;

    localparam int WIDTH = 8;
    localparam int DEPTH = 8;

    logic                    clk = 1'b0;
    logic                    xrst = 1'b0;
    logic signed [WIDTH-1:0] i_data = '0;
    logic                    i_val = 1'b0;
    logic                    i_last = 1'b0;
    logic                    i_ready;
    logic signed [WIDTH-1:0] o_data;
    logic                    o_val;
    logic                    o_last;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int n;
        int vals[8];
        bit use_last;
        int exp[8];
    } vec_t;

    vec_t vecs[4];

    ldpc_ext_sub #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk    (clk),
        .xrst   (xrst),
        .i_data (i_data),
        .i_val  (i_val),
        .i_last (i_last),
        .i_ready(i_ready),
        .o_data (o_data),
        .o_val  (o_val),
        .o_last (o_last)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // Reference fit: saturate or wrap into the signed WIDTH-bit range using modular arithmetic.
    function automatic int model_fit(input int v);
        int span;
        int r;
        span = 1 << WIDTH;
`ifdef LDPC_EXT_SAT_EN
        if (v > span / 2 - 1) return span / 2 - 1;
        if (v < -(span / 2)) return -(span / 2);
        return v;
`else
        r = (v + span / 2) % span;
        if (r < 0) r += span;
        return r - span / 2;
`endif
    endfunction

    // Presents n messages; returns 1 ns after the edge that accepts the last one.
    task automatic send_group(input int vals[8], input int n, input bit use_last);
        for (int i = 0; i < n; i++) begin
            int wait_cyc;
            @(negedge clk);
            wait_cyc = 0;
            while (!i_ready && wait_cyc < 50) begin
                @(negedge clk);
                wait_cyc++;
            end
            if (!i_ready) chk("ready_timeout", 0, 1);
            i_data = WIDTH'(vals[i]);
            i_val  = 1'b1;
            i_last = use_last && (i == n - 1);
            @(posedge clk);
            #1;
            i_val  = 1'b0;
            i_last = 1'b0;
        end
    endtask

    // Checks the full output window that follows a closed group.
    task automatic collect(input string tag, input int exp[8], input int n);
        @(negedge clk);
        chk({tag, "_lat_oval"}, int'(o_val), 0);
        chk({tag, "_lat_ready"}, int'(i_ready), 0);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            chk({tag, "_oval"}, int'(o_val), 1);
            chk({tag, "_odata"}, int'(o_data), exp[k]);
            chk({tag, "_olast"}, int'(o_last), (k == n - 1) ? 1 : 0);
            chk({tag, "_ready"}, int'(i_ready), (k == n - 1) ? 1 : 0);
        end
        @(negedge clk);
        chk({tag, "_post_oval"}, int'(o_val), 0);
        chk({tag, "_post_olast"}, int'(o_last), 0);
    endtask

    initial begin
        int v8[8];
        int e8[8];
        int sum;
        int n;
        bit ul;

        vecs[0].n = 3; vecs[0].use_last = 1'b1;
        vecs[0].vals = '{3, -5, 7, 0, 0, 0, 0, 0};
        vecs[0].exp  = '{2, 10, -2, 0, 0, 0, 0, 0};
        vecs[1].n = 1; vecs[1].use_last = 1'b1;
        vecs[1].vals = '{5, 0, 0, 0, 0, 0, 0, 0};
        vecs[1].exp  = '{0, 0, 0, 0, 0, 0, 0, 0};
        vecs[2].n = 3; vecs[2].use_last = 1'b1;
        vecs[2].vals = '{127, 127, 127, 0, 0, 0, 0, 0};
`ifdef LDPC_EXT_SAT_EN
        vecs[2].exp  = '{127, 127, 127, 0, 0, 0, 0, 0};
`else
        vecs[2].exp  = '{-2, -2, -2, 0, 0, 0, 0, 0};
`endif
        vecs[3].n = 8; vecs[3].use_last = 1'b0;
        vecs[3].vals = '{1, 1, 1, 1, 1, 1, 1, 1};
        vecs[3].exp  = '{7, 7, 7, 7, 7, 7, 7, 7};

        #2;
        chk("rst_oval", int'(o_val), 0);
        chk("rst_olast", int'(o_last), 0);
        chk("rst_odata", int'(o_data), 0);
        chk("rst_ready", int'(i_ready), 1);
        repeat (2) @(posedge clk);
        #1 xrst = 1'b1;

        for (int t = 0; t < 4; t++) begin
            send_group(vecs[t].vals, vecs[t].n, vecs[t].use_last);
            collect($sformatf("vec%0d", t), vecs[t].exp, vecs[t].n);
        end

        // Input offered during EMIT must be ignored.
        v8 = '{4, 6, 0, 0, 0, 0, 0, 0};
        e8 = '{6, 4, 0, 0, 0, 0, 0, 0};
        send_group(v8, 2, 1'b1);
        fork
            collect("ignore", e8, 2);
            begin
                i_data = 8'sd99;
                i_val  = 1'b1;
                i_last = 1'b1;
                repeat (2) @(posedge clk);
                #1;
                i_val  = 1'b0;
                i_last = 1'b0;
            end
        join
        v8 = '{1, 2, 0, 0, 0, 0, 0, 0};
        e8 = '{2, 1, 0, 0, 0, 0, 0, 0};
        send_group(v8, 2, 1'b1);
        collect("after_ignore", e8, 2);

        // Reset in the second EMIT cycle discards the group.
        v8 = '{1, 2, 3, 0, 0, 0, 0, 0};
        send_group(v8, 3, 1'b1);
        @(negedge clk);
        @(negedge clk);
        chk("mid_first_odata", int'(o_data), 5);
        #1 xrst = 1'b0;
        #1;
        chk("mid_rst_oval", int'(o_val), 0);
        chk("mid_rst_odata", int'(o_data), 0);
        chk("mid_rst_olast", int'(o_last), 0);
        chk("mid_rst_ready", int'(i_ready), 1);
        @(negedge clk);
        xrst = 1'b1;
        v8 = '{10, -10, 0, 0, 0, 0, 0, 0};
        e8 = '{-10, 10, 0, 0, 0, 0, 0, 0};
        send_group(v8, 2, 1'b1);
        collect("after_rst", e8, 2);

        for (int r = 0; r < 40; r++) begin
            n = int'($urandom_range(1, DEPTH));
            ul = (n < DEPTH) ? 1'b1 : 1'($urandom_range(0, 1));
            sum = 0;
            for (int i = 0; i < 8; i++) begin
                v8[i] = (i < n) ? int'($urandom_range(0, 255)) - 128 : 0;
                sum += v8[i];
            end
            for (int i = 0; i < 8; i++) e8[i] = (i < n) ? model_fit(sum - v8[i]) : 0;
            send_group(v8, n, ul);
            collect($sformatf("rnd%0d", r), e8, n);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
